// File: rtl/float_reduce_pkg.sv
// Shared types and IEEE-754 single-precision helpers for the float reduction blocks.
package float_reduce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_ACCEPT,
    ST_WAIT_CMP,
    ST_DONE
  } argmin_state_t;

  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/float_lessthan.sv
// Two-stage pipelined IEEE-754 single-precision less-than: q = (in1 < in2).
// NaN operands compare false; -0.0 and +0.0 compare equal.
module float_lessthan
  import float_reduce_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        in_valid,
  output logic        q,
  output logic        q_valid
);

  logic lt_d, lt_q;
  logic v1_d, v1_q;
  logic q_d, q_q;
  logic qv_d, qv_q;

  logic        sa, sb;
  logic [30:0] ma, mb;
  logic        both_zero;
  logic        any_nan;

  always_comb begin
    sa        = in1[31];
    sb        = in2[31];
    ma        = in1[30:0];
    mb        = in2[30:0];
    both_zero = (ma == 31'd0) && (mb == 31'd0);
    any_nan   = fp_is_nan(in1) || fp_is_nan(in2);
    lt_d      = 1'b0;
    if (!any_nan && !both_zero) begin
      // Sign-magnitude order: magnitude order flips for two negatives.
      if (sa && !sb)       lt_d = 1'b1;
      else if (!sa && !sb) lt_d = (ma < mb);
      else if (sa && sb)   lt_d = (ma > mb);
      else                 lt_d = 1'b0;
    end
    v1_d = in_valid;
    q_d  = lt_q;
    qv_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q <= 1'b0;
      v1_q <= 1'b0;
      q_q  <= 1'b0;
      qv_q <= 1'b0;
    end else begin
      lt_q <= lt_d;
      v1_q <= v1_d;
      q_q  <= q_d;
      qv_q <= qv_d;
    end
  end

  assign q       = q_q;
  assign q_valid = qv_q;

endmodule

// File: rtl/float_argmin_reduce.sv
// Streaming arg-min over a vector of single-precision floats, one element per comparator round trip.
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_FIRST    | accepting element 0 as the initial minimum
//   ST_ACCEPT   | accepting the next candidate
//   ST_WAIT_CMP | candidate in flight through the comparator
//   ST_DONE     | result presented until out_ready
module float_argmin_reduce
  import float_reduce_pkg::*;
#(
  parameter int          IDX_W     = 16,
  parameter logic [31:0] EMPTY_MIN = FP_POS_INF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] length,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_min,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  argmin_state_t    state_d, state_q;
  logic [IDX_W-1:0] len_d, len_q;
  logic [IDX_W-1:0] count_d, count_q;
  logic [31:0]      cur_min_d, cur_min_q;
  logic [IDX_W-1:0] cur_idx_d, cur_idx_q;
  logic [31:0]      cand_d, cand_q;
  logic [IDX_W-1:0] cand_idx_d, cand_idx_q;
  logic             cmp_valid_d, cmp_valid_q;
  logic             pending_d, pending_q;
  logic [31:0]      out_min_d, out_min_q;
  logic [IDX_W-1:0] out_idx_d, out_idx_q;
  logic             out_valid_d, out_valid_q;
  logic             in_ready_d, in_ready_q;
  logic             busy_d, busy_q;

  logic             cmp_q, cmp_q_valid;
  logic             take_cand;
  logic [31:0]      new_min;
  logic [IDX_W-1:0] new_idx;
  logic [IDX_W-1:0] next_count;
  logic             in_hs;

  float_lessthan u_lessthan (
    .clk      (clk),
    .rst      (~reset),
    .in1      (cand_q),
    .in2      (cur_min_q),
    .in_valid (cmp_valid_q),
    .q        (cmp_q),
    .q_valid  (cmp_q_valid)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    cur_min_d   = cur_min_q;
    cur_idx_d   = cur_idx_q;
    cand_d      = cand_q;
    cand_idx_d  = cand_idx_q;
    cmp_valid_d = 1'b0;
    pending_d   = pending_q;
    out_min_d   = out_min_q;
    out_idx_d   = out_idx_q;

    in_hs      = in_valid && in_ready_q;
    // A NaN running minimum yields to any real candidate; the comparator alone would never say so.
    take_cand  = cmp_q || (fp_is_nan(cur_min_q) && !fp_is_nan(cand_q));
    new_min    = take_cand ? cand_q : cur_min_q;
    new_idx    = take_cand ? cand_idx_q : cur_idx_q;
    next_count = count_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = length;
          count_d = '0;
          if (length == '0) begin
            state_d   = ST_DONE;
            out_min_d = EMPTY_MIN;
            out_idx_d = '1;
          end else begin
            state_d = ST_FIRST;
          end
        end
      end
      ST_FIRST: begin
        if (in_hs) begin
          cur_min_d = in_data;
          cur_idx_d = '0;
          count_d   = next_count;
          if (next_count == len_q) begin
            state_d   = ST_DONE;
            out_min_d = in_data;
            out_idx_d = '0;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        if (in_hs) begin
          cand_d      = in_data;
          cand_idx_d  = count_q;
          cmp_valid_d = 1'b1;
          pending_d   = 1'b1;
          state_d     = ST_WAIT_CMP;
        end
      end
      ST_WAIT_CMP: begin
        if (pending_q && cmp_q_valid) begin
          pending_d = 1'b0;
          cur_min_d = new_min;
          cur_idx_d = new_idx;
          count_d   = next_count;
          if (next_count == len_q) begin
            state_d   = ST_DONE;
            out_min_d = new_min;
            out_idx_d = new_idx;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_FIRST) || (state_d == ST_ACCEPT);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      cur_min_q   <= '0;
      cur_idx_q   <= '0;
      cand_q      <= '0;
      cand_idx_q  <= '0;
      cmp_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      out_min_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      cur_min_q   <= cur_min_d;
      cur_idx_q   <= cur_idx_d;
      cand_q      <= cand_d;
      cand_idx_q  <= cand_idx_d;
      cmp_valid_q <= cmp_valid_d;
      pending_q   <= pending_d;
      out_min_q   <= out_min_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_min   = out_min_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_float_argmin_reduce.sv
// Directed bench for float_argmin_reduce: hand-computed arg-min vectors and protocol corners.
module tb_float_argmin_reduce;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] length;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_min;
  logic [15:0] out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] vec [0:7];

  float_argmin_reduce #(.IDX_W(16), .EMPTY_MIN(32'h7F800000)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
  endtask

  // Feeds vec[0..n-1]; ok drops if in_ready never shows up within the budget.
  task automatic feed(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      in_data  = vec[i];
      in_valid = 1'b1;
      for (int c = 0; c < 40 && !got; c++) begin
        if (in_ready) got = 1'b1;
        tick();
      end
      in_valid = 1'b0;
      if (!got) ok = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input int n, input logic [31:0] exp_min,
                         input logic [15:0] exp_idx);
    bit ok;
    start_op(16'(n));
    feed(n, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s feed: in_ready timeout, got ok=%0b want 1", name, ok);
    end
    wait_out(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s out_valid: timeout, got %0b want 1", name, out_valid);
    end
    n_cmp++;
    if (out_min !== exp_min) begin
      n_err++;
      $display("FAIL %s out_min: got %h want %h", name, out_min, exp_min);
    end
    n_cmp++;
    if (out_idx !== exp_idx) begin
      n_err++;
      $display("FAIL %s out_idx: got %h want %h", name, out_idx, exp_idx);
    end
    release_out();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: got out_valid=%0b busy=%0b want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset flags: got in_ready=%0b out_valid=%0b busy=%0b want 000", in_ready, out_valid, busy);
    end
    n_cmp++;
    if (out_min !== 32'h0 || out_idx !== 16'h0) begin
      n_err++;
      $display("FAIL reset outputs: got min=%h idx=%h want 0 0", out_min, out_idx);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    vec[0] = 32'h40400000; vec[1] = 32'h3F800000; vec[2] = 32'h40000000; vec[3] = 32'h3F000000;
    run_vec("basic", 4, 32'h3F000000, 16'd3);
  endtask

  task automatic test_tie();
    vec[0] = 32'h3F800000; vec[1] = 32'hBF800000; vec[2] = 32'hBF800000;
    run_vec("tie", 3, 32'hBF800000, 16'd1);
    vec[0] = 32'h80000000; vec[1] = 32'h00000000;
    run_vec("signed_zero", 2, 32'h80000000, 16'd0);
  endtask

  task automatic test_negatives();
    vec[0] = 32'hBF800000; vec[1] = 32'hC0000000; vec[2] = 32'hBF000000;
    run_vec("negatives", 3, 32'hC0000000, 16'd1);
  endtask

  task automatic test_empty();
    start_op(16'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL empty latency: got out_valid=%0b in_ready=%0b want 1 0", out_valid, in_ready);
    end
    n_cmp++;
    if (out_min !== 32'h7F800000 || out_idx !== 16'hFFFF) begin
      n_err++;
      $display("FAIL empty result: got min=%h idx=%h want 7f800000 ffff", out_min, out_idx);
    end
    release_out();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty release: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_nan();
    vec[0] = 32'h7FC00000; vec[1] = 32'h40000000; vec[2] = 32'h7FC00001;
    run_vec("nan", 3, 32'h40000000, 16'd1);
    vec[0] = 32'h7FC00000; vec[1] = 32'h7FC00001;
    run_vec("all_nan", 2, 32'h7FC00000, 16'd0);
  endtask

  task automatic test_abort();
    bit ok;
    vec[0] = 32'h3F800000; vec[1] = 32'h40000000;
    start_op(16'd4);
    feed(2, ok);
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL abort flags: got in_ready=%0b out_valid=%0b busy=%0b want 000", in_ready, out_valid, busy);
    end
    reset = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort stale: got out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
    vec[0] = 32'hC0000000;
    run_vec("after_abort", 1, 32'hC0000000, 16'd0);
  endtask

  task automatic test_hold();
    bit ok;
    vec[0] = 32'h3F800000;
    start_op(16'd1);
    feed(1, ok);
    wait_out(ok);
    for (int c = 0; c < 5; c++) begin
      start  = c[0];
      length = 16'd0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_min !== 32'h3F800000 || out_idx !== 16'd0) begin
        n_err++;
        $display("FAIL hold cycle %0d: got v=%0b min=%h idx=%h want 1 3f800000 0", c, out_valid, out_min, out_idx);
      end
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL hold release: got out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done ignored: got busy=%0b out_valid=%0b want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    length    = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_negatives();
    test_empty();
    test_nan();
    test_abort();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
